// File: rtl/cache_refill_ctrl_if.sv
// CPU request, memory request/refill and data/tag store write signals of the refill controller.
// The master modport is the controller's view; slave is the surrounding cache/memory view.
interface cache_refill_ctrl_if;
  logic        req_valid;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        hit;
  logic        resp_valid;
  logic        stall;

  logic        mem_req_valid;
  logic        mem_req_write;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_wdata;
  logic        mem_req_ready;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;

  logic        fill_we;
  logic [1:0]  fill_way;
  logic [11:0] fill_index;
  logic [1:0]  fill_word;
  logic [31:0] fill_data;
  logic        tag_we;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, hit,
    input  mem_req_ready, mem_resp_valid, mem_resp_data,
    output req_ready, resp_valid, stall,
    output mem_req_valid, mem_req_write, mem_req_addr, mem_req_wdata,
    output fill_we, fill_way, fill_index, fill_word, fill_data, tag_we
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, hit,
    output mem_req_ready, mem_resp_valid, mem_resp_data,
    input  req_ready, resp_valid, stall,
    input  mem_req_valid, mem_req_write, mem_req_addr, mem_req_wdata,
    input  fill_we, fill_way, fill_index, fill_word, fill_data, tag_we
  );
endinterface

// File: rtl/cache_refill_ctrl.sv
// Write-through, no-write-allocate cache refill controller with random (LFSR) victim selection.
// Defining CACHE_PERF_CNT_EN adds hit_count/miss_count access counters.
module cache_refill_ctrl #(
  parameter int unsigned LINE_WORDS = 4,
  parameter logic [7:0]  LFSR_SEED  = 8'h01
) (
  input  logic                 clk,
  input  logic                 rstn,
`ifdef CACHE_PERF_CNT_EN
  output logic [31:0]          hit_count,
  output logic [31:0]          miss_count,
`endif
  cache_refill_ctrl_if.master  bus
);

  localparam logic [1:0] LastBeat = 2'(LINE_WORDS - 1);

  typedef enum logic [2:0] {StIdle, StWt, StReq, StFill, StDone} state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        write_q, write_d;
  logic [1:0]  beat_q, beat_d;
  logic [1:0]  victim_q, victim_d;
  logic [7:0]  lfsr_q, lfsr_d;
  logic        resp_q, resp_d;
  logic        accept;

  assign accept = (state_q == StIdle) && bus.req_valid;
  // x^8 + x^6 + x^5 + x^4 + 1: maximal length, so a nonzero seed never reaches zero.
  assign lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

  always_comb begin
    state_d           = state_q;
    addr_d            = addr_q;
    wdata_d           = wdata_q;
    write_d           = write_q;
    beat_d            = beat_q;
    victim_d          = victim_q;
    resp_d            = 1'b0;
    bus.req_ready     = 1'b0;
    bus.stall         = 1'b1;
    bus.resp_valid    = resp_q;
    bus.mem_req_valid = 1'b0;
    bus.mem_req_write = 1'b0;
    bus.mem_req_addr  = '0;
    bus.mem_req_wdata = '0;
    bus.fill_we       = 1'b0;
    bus.fill_way      = '0;
    bus.fill_index    = '0;
    bus.fill_word     = '0;
    bus.fill_data     = '0;
    bus.tag_we        = 1'b0;

    unique case (state_q)
      StIdle: begin
        bus.req_ready = 1'b1;
        bus.stall     = 1'b0;
        if (accept) begin
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          write_d = bus.req_write;
          if (bus.req_write) begin
            state_d = StWt;
          end else if (bus.hit) begin
            resp_d = 1'b1;
          end else begin
            state_d  = StReq;
            victim_d = lfsr_q[1:0];
          end
        end
      end
      StWt: begin
        bus.mem_req_valid = 1'b1;
        bus.mem_req_write = write_q;
        bus.mem_req_addr  = addr_q;
        bus.mem_req_wdata = wdata_q;
        if (bus.mem_req_ready) begin
          resp_d  = 1'b1;
          state_d = StIdle;
        end
      end
      StReq: begin
        bus.mem_req_valid = 1'b1;
        bus.mem_req_addr  = {addr_q[31:4], 4'b0000};
        if (bus.mem_req_ready) begin
          beat_d  = '0;
          state_d = StFill;
        end
      end
      StFill: begin
        bus.fill_way   = victim_q;
        bus.fill_index = addr_q[15:4];
        bus.fill_word  = beat_q;
        if (bus.mem_resp_valid) begin
          bus.fill_we   = 1'b1;
          bus.fill_data = bus.mem_resp_data;
          beat_d        = beat_q + 2'd1;
          if (beat_q == LastBeat) begin
            beat_d  = '0;
            resp_d  = 1'b1;
            state_d = StDone;
          end
        end
      end
      StDone: begin
        // Tag/valid commit for the line just filled; resp_q was set on the last beat.
        bus.tag_we     = 1'b1;
        bus.fill_way   = victim_q;
        bus.fill_index = addr_q[15:4];
        state_d        = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      wdata_q  <= '0;
      write_q  <= 1'b0;
      beat_q   <= '0;
      victim_q <= '0;
      lfsr_q   <= LFSR_SEED;
      resp_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      write_q  <= write_d;
      beat_q   <= beat_d;
      victim_q <= victim_d;
      lfsr_q   <= lfsr_d;
      resp_q   <= resp_d;
    end
  end

`ifdef CACHE_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rstn) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (accept) begin
      if (bus.hit) hit_count <= hit_count + 32'd1;
      else         miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Self-checking bench for cache_refill_ctrl: directed vector table, reset-abort sequence and
// randomized transactions checked against a transaction-level model.
module tb_cache_refill_ctrl;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  cache_refill_ctrl_if bus();

`ifdef CACHE_PERF_CNT_EN
  logic [31:0] hit_count, miss_count;
`endif

  cache_refill_ctrl #(
    .LINE_WORDS(4),
    .LFSR_SEED (8'h01)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
`ifdef CACHE_PERF_CNT_EN
    .hit_count (hit_count),
    .miss_count(miss_count),
`endif
    .bus       (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_hits = 0;
  logic [31:0] exp_misses = 0;
  logic [3:0]  way_seen = '0;

  // Reference victim source: 8-bit Fibonacci LFSR, taps 8,6,5,4, stepping every clock.
  logic [7:0] m_lfsr;
  always @(posedge clk) begin
    if (!rstn) m_lfsr <= 8'h01;
    else       m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end

  typedef struct {
    logic        write;
    logic        hit;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          ready_wait;
    int          gap;
    logic [31:0] beat_base;
    logic [31:0] exp_mem_addr;
  } vec_t;

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet_inputs();
    bus.req_valid      = 1'b0;
    bus.req_write      = 1'b0;
    bus.req_addr       = '0;
    bus.req_wdata      = '0;
    bus.hit            = 1'b0;
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_data  = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check1 ({tag, " req_ready"},     bus.req_ready, 1'b1);
    check1 ({tag, " stall"},         bus.stall, 1'b0);
    check1 ({tag, " resp_valid"},    bus.resp_valid, 1'b0);
    check1 ({tag, " mem_req_valid"}, bus.mem_req_valid, 1'b0);
    check1 ({tag, " mem_req_write"}, bus.mem_req_write, 1'b0);
    check32({tag, " mem_req_addr"},  bus.mem_req_addr, 32'h0);
    check32({tag, " mem_req_wdata"}, bus.mem_req_wdata, 32'h0);
    check1 ({tag, " fill_we"},       bus.fill_we, 1'b0);
    check32({tag, " fill_way"},      32'(bus.fill_way), 32'h0);
    check32({tag, " fill_index"},    32'(bus.fill_index), 32'h0);
    check32({tag, " fill_word"},     32'(bus.fill_word), 32'h0);
    check32({tag, " fill_data"},     bus.fill_data, 32'h0);
    check1 ({tag, " tag_we"},        bus.tag_we, 1'b0);
  endtask

  // Drives one complete access; starts and ends just after a rising edge.
  task automatic run_txn(input vec_t v, input bit stray);
    logic [1:0] victim;
    bus.req_valid = 1'b1;
    bus.req_write = v.write;
    bus.hit       = v.hit;
    bus.req_addr  = v.addr;
    bus.req_wdata = v.wdata;
    bus.mem_resp_valid = stray ? 1'($urandom) : 1'b0;
    @(negedge clk);
    check1("accept req_ready", bus.req_ready, 1'b1);
    check1("accept stall", bus.stall, 1'b0);
    check1("accept fill_we", bus.fill_we, 1'b0);
    victim = m_lfsr[1:0];
    if (v.hit) exp_hits++;
    else       exp_misses++;
    next_cycle();
    // Scramble request inputs: the access must run on the latched copy.
    bus.req_valid = 1'b0;
    bus.req_addr  = $urandom;
    bus.req_wdata = $urandom;
    bus.hit       = 1'($urandom);
    bus.req_write = 1'($urandom);
    if (!v.write && v.hit) begin
      bus.mem_resp_valid = stray ? 1'($urandom) : 1'b0;
      @(negedge clk);
      check1("hit resp_valid", bus.resp_valid, 1'b1);
      check1("hit stall", bus.stall, 1'b0);
      check1("hit mem_req_valid", bus.mem_req_valid, 1'b0);
      check1("hit fill_we", bus.fill_we, 1'b0);
      next_cycle();
      bus.mem_resp_valid = 1'b0;
    end else begin
      for (int i = 0; i <= v.ready_wait; i++) begin
        bus.mem_req_ready  = (i == v.ready_wait);
        bus.mem_resp_valid = stray ? 1'($urandom) : 1'b0;
        @(negedge clk);
        check1 ("mreq valid", bus.mem_req_valid, 1'b1);
        check1 ("mreq write", bus.mem_req_write, v.write);
        check32("mreq addr", bus.mem_req_addr, v.exp_mem_addr);
        if (v.write) check32("mreq wdata", bus.mem_req_wdata, v.wdata);
        check1 ("mreq stall", bus.stall, 1'b1);
        check1 ("mreq req_ready", bus.req_ready, 1'b0);
        check1 ("mreq resp_valid", bus.resp_valid, 1'b0);
        check1 ("mreq fill_we", bus.fill_we, 1'b0);
        next_cycle();
      end
      bus.mem_req_ready  = 1'b0;
      bus.mem_resp_valid = 1'b0;
      if (v.write) begin
        @(negedge clk);
        check1("store resp_valid", bus.resp_valid, 1'b1);
        check1("store mem_req_valid", bus.mem_req_valid, 1'b0);
        check1("store fill_we", bus.fill_we, 1'b0);
        check1("store stall", bus.stall, 1'b0);
        next_cycle();
      end else begin
        for (int b = 0; b < 4; b++) begin
          for (int g = 0; g < v.gap; g++) begin
            bus.mem_resp_valid = 1'b0;
            @(negedge clk);
            check1("gap fill_we", bus.fill_we, 1'b0);
            check1("gap stall", bus.stall, 1'b1);
            next_cycle();
          end
          bus.mem_resp_valid = 1'b1;
          bus.mem_resp_data  = 32'(v.beat_base * 32'(b + 1));
          @(negedge clk);
          check1 ("beat fill_we", bus.fill_we, 1'b1);
          check32("beat fill_word", 32'(bus.fill_word), 32'(b));
          check32("beat fill_index", 32'(bus.fill_index), 32'(v.addr[15:4]));
          check32("beat fill_way", 32'(bus.fill_way), 32'(victim));
          check32("beat fill_data", bus.fill_data, 32'(v.beat_base * 32'(b + 1)));
          check1 ("beat resp_valid", bus.resp_valid, 1'b0);
          check1 ("beat tag_we", bus.tag_we, 1'b0);
          way_seen[bus.fill_way] = 1'b1;
          next_cycle();
        end
        bus.mem_resp_valid = 1'b0;
        @(negedge clk);
        check1 ("done tag_we", bus.tag_we, 1'b1);
        check1 ("done resp_valid", bus.resp_valid, 1'b1);
        check1 ("done fill_we", bus.fill_we, 1'b0);
        check32("done fill_way", 32'(bus.fill_way), 32'(victim));
        check32("done fill_index", 32'(bus.fill_index), 32'(v.addr[15:4]));
        next_cycle();
        @(negedge clk);
        check1("post resp_valid", bus.resp_valid, 1'b0);
        check1("post tag_we", bus.tag_we, 1'b0);
        check1("post req_ready", bus.req_ready, 1'b1);
        next_cycle();
      end
    end
  endtask

  vec_t vecs[7];
  vec_t rv;
  vec_t abort_v;

  initial begin
    vecs[0] = '{1'b0, 1'b1, 32'h0001_2340, 32'h0,         0, 0, 32'd0,         32'h0};
    vecs[1] = '{1'b0, 1'b0, 32'hABCD_1238, 32'h0,         3, 2, 32'd11,        32'hABCD_1230};
    vecs[2] = '{1'b1, 1'b0, 32'h0000_0010, 32'hDEADBEEF,  0, 0, 32'd0,         32'h0000_0010};
    vecs[3] = '{1'b1, 1'b1, 32'h1234_5678, 32'hCAFEF00D,  2, 0, 32'd0,         32'h1234_5678};
    vecs[4] = '{1'b0, 1'b0, 32'h0000_000C, 32'h0,         0, 0, 32'h100,       32'h0000_0000};
    vecs[5] = '{1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0,         1, 1, 32'h0F0F_0F0F, 32'hFFFF_FFF0};
    vecs[6] = '{1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0,         0, 0, 32'd0,         32'h0};

    quiet_inputs();
    rstn = 1'b0;
    repeat (2) next_cycle();
    bus.mem_resp_valid = 1'b1;
    @(negedge clk);
    check_reset_outputs("reset");
    next_cycle();
    rstn = 1'b1;
    bus.mem_resp_valid = 1'b0;
    next_cycle();

    for (int i = 0; i < 7; i++) run_txn(vecs[i], 1'b0);

    // Reset while beat 3 is still outstanding.
    abort_v = '{1'b0, 1'b0, 32'h0000_5670, 32'h0, 0, 0, 32'h7, 32'h0000_5670};
    bus.req_valid = 1'b1;
    bus.req_addr  = abort_v.addr;
    next_cycle();
    bus.req_valid = 1'b0;
    bus.mem_req_ready = 1'b1;
    next_cycle();
    bus.mem_req_ready = 1'b0;
    for (int b = 0; b < 3; b++) begin
      bus.mem_resp_valid = 1'b1;
      bus.mem_resp_data  = 32'(b + 100);
      @(negedge clk);
      check1("abort beat fill_we", bus.fill_we, 1'b1);
      next_cycle();
    end
    rstn = 1'b0;
    bus.mem_resp_valid = 1'b1;
    next_cycle();
    rstn = 1'b1;
    exp_hits   = 0;
    exp_misses = 0;
    @(negedge clk);
    check_reset_outputs("abort");
    next_cycle();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check1("abort late fill_we", bus.fill_we, 1'b0);
      check1("abort late tag_we", bus.tag_we, 1'b0);
      check1("abort late resp_valid", bus.resp_valid, 1'b0);
      next_cycle();
    end
    bus.mem_resp_valid = 1'b0;
    run_txn(vecs[0], 1'b0);

    // Randomized accesses with stray refill beats outside FILL.
    for (int n = 0; n < 60; n++) begin
      int kind;
      kind = int'($urandom_range(0, 9));
      rv.addr       = $urandom;
      rv.wdata      = $urandom;
      rv.ready_wait = int'($urandom_range(0, 3));
      rv.gap        = int'($urandom_range(0, 2));
      rv.beat_base  = $urandom;
      if (kind < 6) begin
        rv.write = 1'b0; rv.hit = 1'b0; rv.exp_mem_addr = {rv.addr[31:4], 4'h0};
      end else if (kind < 8) begin
        rv.write = 1'b1; rv.hit = 1'($urandom); rv.exp_mem_addr = rv.addr;
      end else begin
        rv.write = 1'b0; rv.hit = 1'b1; rv.exp_mem_addr = 32'h0;
      end
      run_txn(rv, 1'b1);
      if (n % 4 == 0) begin
        bus.mem_resp_valid = 1'b1;
        @(negedge clk);
        check1("idle stray fill_we", bus.fill_we, 1'b0);
        check1("idle stray stall", bus.stall, 1'b0);
        next_cycle();
        bus.mem_resp_valid = 1'b0;
      end
    end
    check32("victim way coverage", 32'(way_seen), 32'hF);

`ifdef CACHE_PERF_CNT_EN
    @(negedge clk);
    check32("hit_count", hit_count, exp_hits);
    check32("miss_count", miss_count, exp_misses);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cache_refill_ctrl.md
CACHE_REFILL_CTRL -- requirements
Module: cache_refill_ctrl

Interface
REQ-001 Parameters SHALL be as follows: LINE_WORDS, 4, 32-bit words per 16-byte line; LFSR_SEED, 8'h01, victim LFSR reset value (nonzero).
REQ-002 clk  in  1  clock; all state changes on rising edge.
REQ-003 rstn  in  1  reset, synchronous, active-low.
REQ-004 req_valid  in  1  CPU access request; req_write  in  1  1=store, 0=load.
REQ-005 req_addr  in  32  byte address (tag[31:16], index[15:4], offset[3:0]); req_wdata  in  32  store data.
REQ-006 req_ready  out  1  request accepted when req_valid&req_ready.
REQ-007 hit  in  1  tag-lookup hit for req_addr, valid in the acceptance cycle.
REQ-008 resp_valid  out  1  one-cycle access-complete pulse; stall  out  1  cache busy (miss/write in progress).
REQ-009 mem_req_valid  out  1; mem_req_write  out  1; mem_req_addr  out  32; mem_req_wdata  out  32; mem_req_ready  in  1  memory request channel.
REQ-010 mem_resp_valid  in  1; mem_resp_data  in  32  refill beat channel.
REQ-011 fill_we  out  1; fill_way  out  2; fill_index  out  12; fill_word  out  2; fill_data  out  32  data-store write port; tag_we  out  1  tag/valid write for fill_way/fill_index.

Function
REQ-012 FSM states SHALL be IDLE, WT, REQ, FILL, DONE; req_ready=1 only in IDLE; stall=1 in every state except IDLE.
REQ-013 On acceptance, addr/wdata/write SHALL be latched; later req_addr/req_wdata changes SHALL be ignored until IDLE.
REQ-014 Load hit (accept with hit=1, req_write=0): stay IDLE, resp_valid=1 next cycle (latency 1).
REQ-015 Store (any hit): IDLE->WT; write-through, no write-allocate; mem_req_valid=1, mem_req_write=1, mem_req_addr=latched addr, mem_req_wdata=latched data, held stable until mem_req_ready; cycle after handshake: resp_valid=1, ->IDLE.
REQ-016 Load miss: IDLE->REQ; victim way = LFSR[1:0] sampled at acceptance; mem_req_valid=1, mem_req_write=0, mem_req_addr={addr[31:4],4'b0} held until mem_req_ready; then ->FILL.
REQ-017 FILL: each mem_resp_valid SHALL produce fill_we=1 same cycle, fill_data=mem_resp_data, fill_word=beat count (0,1,2,3 in order), fill_index=addr[15:4], fill_way=victim; beat counter wraps 3->0.
REQ-018 On beat 3, ->DONE; DONE lasts one cycle with tag_we=1 and resp_valid=1, then ->IDLE.
REQ-019 mem_resp_valid outside FILL SHALL be ignored (no fill_we, no counter change).
REQ-020 mem_req_ready in the first cycle mem_req_valid rises SHALL complete the handshake (zero-wait).
REQ-021 Victim LFSR: 8-bit Fibonacci, taps 8,6,5,4, advances every cycle regardless of state, never zero.
REQ-022 fill_we, tag_we, resp_valid, mem_req_valid SHALL never be 1 simultaneously with a different request's latched address.

Reset
REQ-023 rstn=0 at edge: state=IDLE, beat=0, LFSR=LFSR_SEED, latched addr/data=0; all outputs 0 except req_ready=1.
REQ-024 Reset mid-WT/REQ/FILL SHALL abort: no further fill_we/tag_we/resp_valid for the aborted access; beats arriving after reset ignored.

Configuration
REQ-025 Macro CACHE_PERF_CNT_EN defined: add outputs hit_count out 32, miss_count out 32; hit_count +1 per accepted load hit or store hit, miss_count +1 per accepted load miss or store miss; wrap 32'hFFFFFFFF->0; reset 0.
REQ-026 CACHE_PERF_CNT_EN undefined: ports and counters absent; all other behaviour identical.

Verification
REQ-027 Load hit: req_valid=1, write=0, hit=1, addr=32'h0001_2340 -> resp_valid cycle+1, stall=0, no mem_req_valid.
REQ-028 Load miss, addr=32'hABCD_1238, mem_req_ready after 3 cycles, beats 11,22,33,44 with gaps -> mem_req_addr=32'hABCD_1230; fill_word 0..3 with fill_index=12'h123, data in order; tag_we+resp_valid one cycle after beat 44.
REQ-029 Store, addr=32'h0000_0010, wdata=32'hDEADBEEF, mem_req_ready immediate -> one mem write with those values, resp_valid next cycle, no fill_we.
REQ-030 Reset after beat 2 of a refill -> outputs per REQ-023 next cycle; following beats ignored; next load hit completes normally.
REQ-031 Stray mem_resp_valid=1 in IDLE and WT -> no fill_we; 300 cycles of misses -> fill_way values cover 0..3, LFSR never 0.
